serial_subtractor: RTL and testbench

//  Bit-serial unsigned subtractor, the inverse arithmetic partner of the combinational adders.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 45 ++++
 rtl/full_subtractor_bit.sv | 25 ++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and defaults for the bit-serial subtractor
package serial_subtractor_pkg;

  // Operand width used when no override is given
  localparam int DEFAULT_WIDTH = 8;

  // Control states: idle/load, one bit per cycle, one-cycle result publish
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done request bus of the serial subtractor; ovf with SERIAL_SUB_OVF_EN
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf
  );

  // Subtractor side
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf
  );
`else
  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  // Subtractor side
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
`endif

endinterface

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - one-bit full subtractor built from two cascaded half subtractors
module full_subtractor_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half subtractor: a - b
  assign hs1_d = a_i ^ b_i;
  assign hs1_b = ~a_i & b_i;

  // Second half subtractor: (a - b) - bin
  assign d_o   = hs1_d ^ bin_i;
  assign hs2_b = ~hs1_d & bin_i;

  // A borrow from either stage propagates out
  assign bout_o = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial unsigned subtractor; SERIAL_SUB_OVF_EN adds signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk_i,
  input logic                rst_i,
  serial_subtractor_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic [CNT_W-1:0] count_q;
  logic             bff_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
`endif

  logic fs_d;
  logic fs_bout;

  // The single arithmetic cell: always looks at the current LSBs and the carried borrow
  full_subtractor_bit u_fsb (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (bff_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  // Result bits arrive LSB first, so each new bit enters at the top and earlier ones move down
  assign diff_d = {fs_d, diff_q[WIDTH-1:1]};

  // Control FSM plus serial datapath: load on accepted start, one bit per SHIFT cycle, publish in DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      bff_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            diff_q  <= '0;
            count_q <= '0;
            bff_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // Shift registers lose the sign bits, so keep them for the overflow test
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
`endif
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          diff_q <= diff_d;
          bff_q  <= fs_bout;
          if (count_q == LAST_CNT) begin
            // Last bit: counter is left at its maximum rather than wrapping
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            borrow_q <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
            // Overflow only when operand signs differ and the result sign differs from a
            ovf_q    <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ fs_d);
`endif
            state_q  <= ST_DONE;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor; ovf checks with SERIAL_SUB_OVF_EN
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] g_diff;
  logic       g_borrow;
  logic [7:0] g_hold;
  int         g_done_cyc;
  int         g_busy_cyc;
  int         g_done_cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic       g_ovf;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'(a) - int'(b) + 256;
    return 8'(d % 256);
  endfunction

  function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
    return (int'(a) < int'(b));
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'($signed(a)) - int'($signed(b));
    return (r > 127) || (r < -128);
  endfunction

  // One operation from IDLE; cycle k counts negedges after the one where start was raised.
  // Operands are scrambled after accept; with disturb, start is also held through SHIFT and DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit disturb);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = a;
    sif.b = b;
    g_done_cyc = -1;
    g_busy_cyc = 0;
    g_done_cnt = 0;
    g_diff = 'x;
    g_borrow = 'x;
    g_hold = 'x;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (sif.busy) g_busy_cyc++;
      if (sif.done) begin
        g_done_cnt++;
        if (g_done_cyc < 0) begin
          g_done_cyc = k;
          g_diff = sif.diff;
          g_borrow = sif.borrow;
`ifdef SERIAL_SUB_OVF_EN
          g_ovf = sif.ovf;
`endif
        end
      end
      if (k == 13) g_hold = sif.diff;
      sif.a = 8'($urandom);
      sif.b = 8'($urandom);
      sif.start = (disturb && k <= 9) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] e_diff, input logic e_borrow, input logic e_ovf);
    check({tag, " diff"}, g_diff, e_diff);
    check({tag, " borrow"}, g_borrow, e_borrow);
    check({tag, " done_cycle"}, g_done_cyc, 9);
    check({tag, " busy_cycles"}, g_busy_cyc, 8);
    check({tag, " done_pulses"}, g_done_cnt, 1);
    check({tag, " diff_held"}, g_hold, e_diff);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, g_ovf, e_ovf);
`else
    if (e_ovf !== 1'bx && a === 8'hxx && b === 8'hxx) $display("unreachable");
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int         nd;
    int         c1;
    int         c2;
    logic       saw;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

    rst = 1'b1;
    sif.start = 1'b0;
    sif.a = 8'h00;
    sif.b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset busy", sif.busy, 1'b0);
    check("reset done", sif.done, 1'b0);
    check("reset diff", sif.diff, 8'h00);
    check("reset borrow", sif.borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", sif.ovf, 1'b0);
`endif
    rst = 1'b0;

    // Fixed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0);
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
    end

    // Randomised operands, alternately with start/operand disturbance during the operation
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) rb = ra;
      run_op(ra, rb, (i % 2) == 1);
      check_op($sformatf("rnd%0d a=%0h b=%0h", i, ra, rb), ra, rb,
               ref_diff(ra, rb), ref_borrow(ra, rb), ref_ovf(ra, rb));
    end

    // start held high for 20 cycles: exactly two operations, ten cycles apart
    @(negedge clk);
    sif.a = 8'd10;
    sif.b = 8'd1;
    sif.start = 1'b1;
    nd = 0;
    c1 = -1;
    c2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (sif.done) begin
        nd++;
        check($sformatf("held_start diff at cycle %0d", k), sif.diff, 8'd9);
        if (nd == 1) c1 = k;
        else if (nd == 2) c2 = k;
      end
      if (k == 20) sif.start = 1'b0;
    end
    check("held_start done_count", nd, 2);
    check("held_start first_done", c1, 9);
    check("held_start second_done", c2, 19);

    // Leave borrow (and ovf) set so the reset below has something to clear
    run_op(8'h7F, 8'hFF, 1'b0);
    check_op("pre_reset", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Reset during the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    sif.a = 8'h33;
    sif.b = 8'h10;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before_reset", sif.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", sif.busy, 1'b0);
    check("abort diff", sif.diff, 8'h00);
    check("abort done", sif.done, 1'b0);
    check("abort borrow", sif.borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort ovf", sif.ovf, 1'b0);
`endif
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sif.done || sif.busy) saw = 1'b1;
    end
    check("abort no_activity", saw, 1'b0);
    run_op(8'd7, 8'd2, 1'b0);
    check_op("after_abort", 8'd7, 8'd2, 8'd5, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
